// File: rtl/ahb_mtx_in_stage.sv
// ---------------------------------------------------------------------------
// ahb_mtx_in_stage
//
// Slave-port input stage of the L1 AHB bus matrix, sitting directly in front
// of the per-port address decoder. When the target output stage cannot take
// this port's address phase, the address-phase control is captured into a
// holding register and the master is stalled. Once the output stage accepts
// it, the held transfer is issued to the decoder and the block returns to
// passing the live bus straight through.
//
// Ports
//   HCLK, HRESET           clock, synchronous active-high reset
//   HSELS .. HMASTLOCKS    address-phase signals from the master layer
//   HREADYS                bus HREADY as seen by this port
//   HREADYOUTS, HRESPS     data-phase response returned to the master
//   sel_dec .. ready_dec   address phase presented to the decoder
//   active_dec             target output stage accepts this port's request
//   readyout_dec, resp_dec selected data-phase response from the decoder
// ---------------------------------------------------------------------------
module ahb_mtx_in_stage #(
   parameter int ADDR_W = 32
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSELS,
   input  logic [ADDR_W-1:0] HADDRS,
   input  logic [1:0]        HTRANSS,
   input  logic              HWRITES,
   input  logic [2:0]        HSIZES,
   input  logic [2:0]        HBURSTS,
   input  logic [3:0]        HPROTS,
   input  logic              HMASTLOCKS,
   input  logic              HREADYS,
   output logic              HREADYOUTS,
   output logic [1:0]        HRESPS,
   output logic              sel_dec,
   output logic [ADDR_W-1:0] addr_dec,
   output logic [1:0]        trans_dec,
   output logic              write_dec,
   output logic [2:0]        size_dec,
   output logic [2:0]        burst_dec,
   output logic [3:0]        prot_dec,
   output logic              mastlock_dec,
   output logic              ready_dec,
   input  logic              active_dec,
   input  logic              readyout_dec,
   input  logic [1:0]        resp_dec
);

   typedef enum logic {
      PASS = 1'b0,
      HELD = 1'b1
   } state_t;

   state_t              state;
   state_t              next_state;
   logic                pend_tran;
   logic                load;
   logic                capture;
   logic                held_view;

   logic                hold_sel;
   logic [ADDR_W-1:0]   hold_addr;
   logic [1:0]          hold_trans;
   logic                hold_write;
   logic [2:0]          hold_size;
   logic [2:0]          hold_burst;
   logic [3:0]          hold_prot;
   logic                hold_mastlock;

   assign pend_tran = (state == HELD);

   // A valid NONSEQ/SEQ address phase accepted from the master. Once a
   // transfer is pending the master is stalled, so nothing new can load.
   assign load    = HSELS & HTRANSS[1] & HREADYS & ~pend_tran;
   assign capture = load & ~active_dec;

   // While reset is asserted the outputs behave as in pass mode, so a held
   // transfer is dropped without ever being shown to the decoder.
   assign held_view = pend_tran & ~HRESET;

   // State register.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state <= PASS;
      end else begin
         state <= next_state;
      end
   end

   // Next state: enter HELD when the output stage refuses a new transfer,
   // leave it in the issue cycle (the first cycle the output stage accepts).
   always_comb begin
      next_state = state;
      case (state)
         PASS:    if (capture)    next_state = HELD;
         HELD:    if (active_dec) next_state = PASS;
         default: next_state = PASS;
      endcase
   end

   // Hold registers are written only on capture, so live inputs during a
   // stall can never overwrite the pending address phase.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         hold_sel      <= 1'b0;
         hold_addr     <= '0;
         hold_trans    <= 2'b00;
         hold_write    <= 1'b0;
         hold_size     <= 3'b000;
         hold_burst    <= 3'b000;
         hold_prot     <= 4'h0;
         hold_mastlock <= 1'b0;
      end else if (capture) begin
         hold_sel      <= HSELS;
         hold_addr     <= HADDRS;
         hold_trans    <= HTRANSS;
         hold_write    <= HWRITES;
         hold_size     <= HSIZES;
         hold_burst    <= HBURSTS;
         hold_prot     <= HPROTS;
         hold_mastlock <= HMASTLOCKS;
      end
   end

   // Outputs. In held mode the replayed transfer always starts a new burst
   // from the decoder's point of view, so it is presented as NONSEQ; a held
   // SEQ of a fixed-length burst can no longer be counted against that burst
   // and is therefore relabelled as an undefined-length INCR.
   always_comb begin
      sel_dec      = HSELS;
      addr_dec     = HADDRS;
      trans_dec    = HTRANSS;
      write_dec    = HWRITES;
      size_dec     = HSIZES;
      burst_dec    = HBURSTS;
      prot_dec     = HPROTS;
      mastlock_dec = HMASTLOCKS;
      ready_dec    = HREADYS;
      HREADYOUTS   = readyout_dec;
      HRESPS       = resp_dec;
      if (held_view) begin
         sel_dec      = hold_sel;
         addr_dec     = hold_addr;
         trans_dec    = 2'b10;
         write_dec    = hold_write;
         size_dec     = hold_size;
         burst_dec    = ((hold_trans == 2'b11) && (hold_burst != 3'b000)) ?
                        3'b001 : hold_burst;
         prot_dec     = hold_prot;
         mastlock_dec = hold_mastlock;
         ready_dec    = active_dec;
         HREADYOUTS   = 1'b0;
         HRESPS       = 2'b00;
      end
   end

endmodule

// File: tb/tb_ahb_mtx_in_stage.sv
// ---------------------------------------------------------------------------
// tb_ahb_mtx_in_stage
//
// Directed scoreboard bench for ahb_mtx_in_stage. Each stimulus cycle pushes
// a hand-computed expected output vector; a monitor pops one expectation per
// cycle on the falling edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_ahb_mtx_in_stage;

   typedef struct packed {
      logic        hreadyout;
      logic [1:0]  hresp;
      logic        sel;
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [2:0]  burst;
      logic [3:0]  prot;
      logic        mastlock;
      logic        ready;
   } exp_t;

   logic        clk;
   logic        hreset;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic        hmastlock;
   logic        hready;
   logic        hreadyout;
   logic [1:0]  hresp;
   logic        selDec;
   logic [31:0] addrDec;
   logic [1:0]  transDec;
   logic        writeDec;
   logic [2:0]  sizeDec;
   logic [2:0]  burstDec;
   logic [3:0]  protDec;
   logic        mastlockDec;
   logic        readyDec;
   logic        activeDec;
   logic        readyoutDec;
   logic [1:0]  respDec;

   exp_t  expQ[$];
   string labelQ[$];
   int    checks = 0;
   int    errors = 0;

   ahb_mtx_in_stage #(.ADDR_W(32)) dut (
      .HCLK         (clk),
      .HRESET       (hreset),
      .HSELS        (hsel),
      .HADDRS       (haddr),
      .HTRANSS      (htrans),
      .HWRITES      (hwrite),
      .HSIZES       (hsize),
      .HBURSTS      (hburst),
      .HPROTS       (hprot),
      .HMASTLOCKS   (hmastlock),
      .HREADYS      (hready),
      .HREADYOUTS   (hreadyout),
      .HRESPS       (hresp),
      .sel_dec      (selDec),
      .addr_dec     (addrDec),
      .trans_dec    (transDec),
      .write_dec    (writeDec),
      .size_dec     (sizeDec),
      .burst_dec    (burstDec),
      .prot_dec     (protDec),
      .mastlock_dec (mastlockDec),
      .ready_dec    (readyDec),
      .active_dec   (activeDec),
      .readyout_dec (readyoutDec),
      .resp_dec     (respDec)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the rising edge.
   task automatic applyStimulus(input logic rst, input logic s, input logic [31:0] a,
                                input logic [1:0] t, input logic w, input logic [2:0] sz,
                                input logic [2:0] b, input logic [3:0] p, input logic l,
                                input logic rdy, input logic act, input logic rdyo,
                                input logic [1:0] rsp);
      @(posedge clk);
      #1;
      hreset      = rst;
      hsel        = s;
      haddr       = a;
      htrans      = t;
      hwrite      = w;
      hsize       = sz;
      hburst      = b;
      hprot       = p;
      hmastlock   = l;
      hready      = rdy;
      activeDec   = act;
      readyoutDec = rdyo;
      respDec     = rsp;
   endtask

   // Queue the expected outputs for the cycle just driven.
   task automatic expectOutput(input string name, input logic hro, input logic [1:0] rsp,
                               input logic s, input logic [31:0] a, input logic [1:0] t,
                               input logic w, input logic [2:0] sz, input logic [2:0] b,
                               input logic [3:0] p, input logic l, input logic rdy);
      exp_t e;
      e = '{hreadyout: hro, hresp: rsp, sel: s, addr: a, trans: t, write: w,
            size: sz, burst: b, prot: p, mastlock: l, ready: rdy};
      expQ.push_back(e);
      labelQ.push_back(name);
   endtask

   task automatic checkOutput(input string name, input exp_t exp);
      exp_t act;
      act = '{hreadyout: hreadyout, hresp: hresp, sel: selDec, addr: addrDec,
              trans: transDec, write: writeDec, size: sizeDec, burst: burstDec,
              prot: protDec, mastlock: mastlockDec, ready: readyDec};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got hro=%b resp=%b sel=%b addr=%h trans=%b wr=%b size=%0d burst=%b prot=%h lock=%b rdy=%b, want hro=%b resp=%b sel=%b addr=%h trans=%b wr=%b size=%0d burst=%b prot=%h lock=%b rdy=%b",
                  name, act.hreadyout, act.hresp, act.sel, act.addr, act.trans, act.write,
                  act.size, act.burst, act.prot, act.mastlock, act.ready,
                  exp.hreadyout, exp.hresp, exp.sel, exp.addr, exp.trans, exp.write,
                  exp.size, exp.burst, exp.prot, exp.mastlock, exp.ready);
      end
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkOutput(labelQ.pop_front(), expQ.pop_front());
      end
   end

   initial begin
      hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
      hsize = '0; hburst = '0; hprot = '0; hmastlock = 1'b0; hready = 1'b1;
      activeDec = 1'b0; readyoutDec = 1'b1; respDec = 2'b00;

      // Reset: outputs follow the live inputs.
      applyStimulus(1, 0, 32'h0, 2'b00, 0, 0, 0, 4'h0, 0, 1, 0, 1, 2'b00);
      expectOutput("reset", 1, 2'b00, 0, 32'h0, 2'b00, 0, 0, 0, 4'h0, 0, 1);

      // Pass-through with zero latency.
      applyStimulus(0, 1, 32'h20000040, 2'b10, 1, 2, 0, 4'h3, 0, 1, 1, 1, 2'b00);
      expectOutput("pass_nonseq", 1, 2'b00, 1, 32'h20000040, 2'b10, 1, 2, 0, 4'h3, 0, 1);
      applyStimulus(0, 1, 32'h20000044, 2'b00, 0, 2, 0, 4'h3, 0, 0, 1, 0, 2'b00);
      expectOutput("pass_wait", 0, 2'b00, 1, 32'h20000044, 2'b00, 0, 2, 0, 4'h3, 0, 0);

      // No capture: IDLE, BUSY, deselected.
      applyStimulus(0, 1, 32'h20000048, 2'b00, 0, 0, 0, 4'h0, 0, 1, 0, 1, 2'b00);
      expectOutput("idle_nocap", 1, 2'b00, 1, 32'h20000048, 2'b00, 0, 0, 0, 4'h0, 0, 1);
      applyStimulus(0, 1, 32'h2000004C, 2'b01, 0, 0, 0, 4'h0, 0, 1, 0, 1, 2'b00);
      expectOutput("busy_nocap", 1, 2'b00, 1, 32'h2000004C, 2'b01, 0, 0, 0, 4'h0, 0, 1);
      applyStimulus(0, 0, 32'h30000000, 2'b10, 1, 2, 0, 4'h0, 0, 1, 0, 1, 2'b00);
      expectOutput("desel_nocap", 1, 2'b00, 0, 32'h30000000, 2'b10, 1, 2, 0, 4'h0, 0, 1);
      applyStimulus(0, 0, 32'h12345678, 2'b00, 0, 0, 0, 4'h0, 0, 1, 0, 1, 2'b00);
      expectOutput("still_pass", 1, 2'b00, 0, 32'h12345678, 2'b00, 0, 0, 0, 4'h0, 0, 1);

      // Single stall: capture, two held cycles, issue, back to pass.
      applyStimulus(0, 1, 32'h40001000, 2'b10, 0, 2, 0, 4'hA, 0, 1, 0, 1, 2'b00);
      expectOutput("stall_capture", 1, 2'b00, 1, 32'h40001000, 2'b10, 0, 2, 0, 4'hA, 0, 1);
      applyStimulus(0, 1, 32'hDEADBEEC, 2'b11, 1, 0, 3, 4'h0, 1, 1, 0, 1, 2'b00);
      expectOutput("stall_held1", 0, 2'b00, 1, 32'h40001000, 2'b10, 0, 2, 0, 4'hA, 0, 0);
      applyStimulus(0, 1, 32'hDEADBEEC, 2'b11, 1, 0, 3, 4'h0, 1, 1, 0, 1, 2'b01);
      expectOutput("stall_held2", 0, 2'b00, 1, 32'h40001000, 2'b10, 0, 2, 0, 4'hA, 0, 0);
      applyStimulus(0, 1, 32'hDEADBEEC, 2'b11, 1, 0, 3, 4'h0, 1, 1, 1, 1, 2'b00);
      expectOutput("stall_issue", 0, 2'b00, 1, 32'h40001000, 2'b10, 0, 2, 0, 4'hA, 0, 1);
      applyStimulus(0, 1, 32'hDEADBEEC, 2'b00, 0, 0, 0, 4'h0, 0, 1, 1, 1, 2'b00);
      expectOutput("stall_after", 1, 2'b00, 1, 32'hDEADBEEC, 2'b00, 0, 0, 0, 4'h0, 0, 1);

      // SEQ of INCR4 becomes NONSEQ INCR while held.
      applyStimulus(0, 1, 32'h50000004, 2'b11, 1, 2, 3'b011, 4'h1, 0, 1, 0, 1, 2'b00);
      expectOutput("seq_capture", 1, 2'b00, 1, 32'h50000004, 2'b11, 1, 2, 3'b011, 4'h1, 0, 1);
      applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 0, 4'h0, 0, 1, 0, 1, 2'b00);
      expectOutput("seq_held", 0, 2'b00, 1, 32'h50000004, 2'b10, 1, 2, 3'b001, 4'h1, 0, 0);
      applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 0, 4'h0, 0, 1, 1, 1, 2'b00);
      expectOutput("seq_issue", 0, 2'b00, 1, 32'h50000004, 2'b10, 1, 2, 3'b001, 4'h1, 0, 1);

      // SEQ with SINGLE keeps its burst; left pending for the reset test.
      applyStimulus(0, 1, 32'h60000008, 2'b11, 0, 1, 3'b000, 4'hF, 1, 1, 0, 1, 2'b00);
      expectOutput("single_capture", 1, 2'b00, 1, 32'h60000008, 2'b11, 0, 1, 3'b000, 4'hF, 1, 1);
      applyStimulus(0, 0, 32'h0, 2'b00, 0, 0, 0, 4'h0, 0, 0, 0, 1, 2'b00);
      expectOutput("single_held", 0, 2'b00, 1, 32'h60000008, 2'b10, 0, 1, 3'b000, 4'hF, 1, 0);

      // Reset while pending discards the held transfer.
      applyStimulus(1, 0, 32'h70000000, 2'b00, 0, 0, 0, 4'h0, 0, 1, 0, 0, 2'b00);
      expectOutput("reset_in_hold", 0, 2'b00, 0, 32'h70000000, 2'b00, 0, 0, 0, 4'h0, 0, 1);
      applyStimulus(0, 0, 32'h70000004, 2'b00, 0, 0, 0, 4'h0, 0, 1, 0, 1, 2'b00);
      expectOutput("after_reset", 1, 2'b00, 0, 32'h70000004, 2'b00, 0, 0, 0, 4'h0, 0, 1);

      // ERROR response passes through cycle-exact.
      applyStimulus(0, 0, 32'h80000000, 2'b00, 0, 0, 0, 4'h0, 0, 0, 0, 0, 2'b01);
      expectOutput("error_first", 0, 2'b01, 0, 32'h80000000, 2'b00, 0, 0, 0, 4'h0, 0, 0);
      applyStimulus(0, 0, 32'h80000000, 2'b00, 0, 0, 0, 4'h0, 0, 1, 0, 1, 2'b01);
      expectOutput("error_second", 1, 2'b01, 0, 32'h80000000, 2'b00, 0, 0, 0, 4'h0, 0, 1);

      // Issue in the very next cycle: exactly one stalled cycle.
      applyStimulus(0, 1, 32'h90000010, 2'b10, 1, 0, 3'b010, 4'h2, 0, 1, 0, 1, 2'b00);
      expectOutput("quick_capture", 1, 2'b00, 1, 32'h90000010, 2'b10, 1, 0, 3'b010, 4'h2, 0, 1);
      applyStimulus(0, 1, 32'h90000014, 2'b11, 0, 1, 3'b001, 4'h0, 0, 1, 1, 1, 2'b00);
      expectOutput("quick_issue", 0, 2'b00, 1, 32'h90000010, 2'b10, 1, 0, 3'b010, 4'h2, 0, 1);
      applyStimulus(0, 1, 32'h90000014, 2'b11, 0, 1, 3'b001, 4'h0, 0, 1, 1, 0, 2'b00);
      expectOutput("quick_after", 0, 2'b00, 1, 32'h90000014, 2'b11, 0, 1, 3'b001, 4'h0, 0, 1);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
      if (expQ.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
